foo_correction_ctrl: RTL

//  Control sequencer for the 2-stage FOO correction pipeline. Converts a valid/ready pixel stream

---
 rtl/foo_correction_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/foo_correction_ctrl.sv
// foo_correction_ctrl: stage-enable sequencer, Bayer row-parity tracker and
// frame-boundary config shadowing for the 2-stage FOO correction datapath.
module foo_correction_ctrl #(
  parameter int unsigned p_pipeline_num_bit = 2,
  parameter int unsigned p_foo_gain_vec_bit = 30,
  parameter int unsigned p_thres_bayer_bit  = 14,
  parameter int unsigned p_y_gain_sft_bit   = 4,
  parameter int unsigned p_pedestal_bit     = 13
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic                          i_IN_VLD,
  output logic                          o_IN_RDY,
  input  logic                          i_IN_SOF,
  input  logic                          i_IN_EOL,
  output logic                          o_OUT_VLD,
  input  logic                          i_OUT_RDY,
  output logic [p_pipeline_num_bit-1:0] o_ENA_VEC,
  output logic                          o_Y_LSB,
  input  logic                          i_CFG_UPD,
  input  logic [1:0]                    i_CFG_ARR_TYPE,
  input  logic [p_foo_gain_vec_bit-1:0] i_CFG_COEFF_VEC,
  input  logic [p_thres_bayer_bit-1:0]  i_CFG_THRES_BAYER,
  input  logic [p_y_gain_sft_bit-1:0]   i_CFG_Y_GAIN_SFT,
  input  logic [p_pedestal_bit-1:0]     i_CFG_PEDESTAL,
  output logic [1:0]                    o_ARR_TYPE,
  output logic [p_foo_gain_vec_bit-1:0] o_COEFF_VEC,
  output logic [p_thres_bayer_bit-1:0]  o_REG_FOO_THRES_BAYER,
  output logic [p_y_gain_sft_bit-1:0]   o_REG_FOO_Y_GAIN_SFT,
  output logic [p_pedestal_bit-1:0]     o_REG_FOO_PEDESTAL,
  output logic                          o_CFG_PEND
);

  typedef struct packed {
    logic [1:0]                    arr_type;
    logic [p_foo_gain_vec_bit-1:0] coeff_vec;
    logic [p_thres_bayer_bit-1:0]  thres_bayer;
    logic [p_y_gain_sft_bit-1:0]   y_gain_sft;
    logic [p_pedestal_bit-1:0]     pedestal;
  } cfg_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   v1_q, v1_d;
  logic   v2_q, v2_d;
  logic   r_y_q, r_y_d;
  logic   pend_q, pend_d;
  cfg_t   shadow_q, shadow_d;
  cfg_t   active_q, active_d;
  cfg_t   cfg_in;

  logic accept_ok;
  logic rdy1, rdy2;
  logic in_fire;
  logic y_lsb;

  assign cfg_in = '{arr_type:    i_CFG_ARR_TYPE,
                    coeff_vec:   i_CFG_COEFF_VEC,
                    thres_bayer: i_CFG_THRES_BAYER,
                    y_gain_sft:  i_CFG_Y_GAIN_SFT,
                    pedestal:    i_CFG_PEDESTAL};

  // Stage readiness, input gating and stage enables.
  always_comb begin
    rdy2      = ~v2_q | i_OUT_RDY;
    rdy1      = ~v1_q | rdy2;
    o_IN_RDY  = rdy1 & accept_ok;
    in_fire   = i_IN_VLD & o_IN_RDY;
    o_ENA_VEC = '0;
    o_ENA_VEC[0] = in_fire;
    o_ENA_VEC[1] = v1_q & rdy2;
  end

  // Config FSM: block a SOF beat while an update is pending, drain, then apply.
  always_comb begin
    state_d   = state_q;
    accept_ok = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (pend_q && i_IN_VLD && i_IN_SOF) begin
          accept_ok = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        accept_ok = 1'b0;
        if (!v1_q && !v2_q) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        accept_ok = 1'b0;
        state_d   = ST_RUN;
      end
      default: begin
        accept_ok = 1'b0;
        state_d   = ST_RUN;
      end
    endcase
  end

  // Pipeline valid bits advance only when the downstream stage can take data.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (rdy1) v1_d = in_fire;
    if (rdy2) v2_d = v1_q;
  end

  // Row parity: SOF forces even row; EOL flips parity for the next line.
  always_comb begin
    y_lsb = i_IN_SOF ? 1'b0 : r_y_q;
    r_y_d = r_y_q;
    if (in_fire && i_IN_EOL)      r_y_d = ~y_lsb;
    else if (in_fire && i_IN_SOF) r_y_d = 1'b0;
  end

  // Shadow capture on every update pulse; active copy loads only in APPLY.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (state_q == ST_APPLY) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (i_CFG_UPD) begin
      shadow_d = cfg_in;
      pend_d   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Pipeline valids and row parity registers.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      r_y_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      r_y_q <= r_y_d;
    end
  end

  // Shadow/active config and pending flag registers.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  assign o_OUT_VLD             = v2_q;
  assign o_Y_LSB               = y_lsb;
  assign o_CFG_PEND            = pend_q;
  assign o_ARR_TYPE            = active_q.arr_type;
  assign o_COEFF_VEC           = active_q.coeff_vec;
  assign o_REG_FOO_THRES_BAYER = active_q.thres_bayer;
  assign o_REG_FOO_Y_GAIN_SFT  = active_q.y_gain_sft;
  assign o_REG_FOO_PEDESTAL    = active_q.pedestal;

endmodule
